// File: rtl/imem_if.sv
// Fetch-side request/response channel for the instruction-memory responder.
// The master (fetch) issues byte-addressed reads; the slave returns one word per request.
interface imem_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Word-addressed program store answering one fetch read at a time, LAT cycles after accept.
// A response is held until resp_ready; req_ready is low while a read is in flight or the loader writes.
module imem_responder #(
   parameter int DEPTH = 1024,
   parameter int LAT   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   imem_if.slave                    bus,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_data_q;
   logic [31:0] mem [DEPTH];

   logic          accept;
   logic          addr_err;
   logic [AW-1:0] rd_idx;

   assign addr_err      = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:AW+2]);
   assign rd_idx        = bus.req_addr[AW+1:2];
   assign bus.req_ready = !load_en && (state == S_IDLE || (state == S_RESP && bus.resp_ready));
   assign accept        = bus.req_valid && bus.req_ready;
   assign busy          = (state != S_IDLE);

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;

   // Loader owns the contents; reset deliberately leaves them intact.
   always_ff @(posedge clk) begin
      if (load_en)
         mem[load_addr] <= load_data;
   end

   // Data is captured at the accepting edge, so later loader writes cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= 2'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'h0;
      end else if (accept) begin
         resp_err_q  <= addr_err;
         resp_data_q <= addr_err ? 32'h0 : mem[rd_idx];
         if (LAT == 1) begin
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
         end else begin
            state        <= S_WAIT;
            cnt          <= CNT_INIT;
            resp_valid_q <= 1'b0;
         end
      end else begin
         case (state)
            S_WAIT: begin
               if (cnt == 2'd0) begin
                  state        <= S_RESP;
                  resp_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  state        <= S_IDLE;
                  resp_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: one LAT=1 responder for streaming, one LAT=3 responder for timing/error/loader cases.
module tb_imem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_if bus1 ();
   imem_if bus3 ();

   logic       load_en1, load_en3;
   logic [9:0] load_addr1, load_addr3;
   logic [31:0] load_data1, load_data3;
   logic       busy1, busy3;

   imem_responder #(.DEPTH(1024), .LAT(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1), .busy(busy1)
   );
   imem_responder #(.DEPTH(1024), .LAT(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3),
      .load_en(load_en3), .load_addr(load_addr3), .load_data(load_data3), .busy(busy3)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] model [1024];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_both(input int idx, input logic [31:0] data);
      load_en1 = 1'b1; load_addr1 = 10'(idx); load_data1 = data;
      load_en3 = 1'b1; load_addr3 = 10'(idx); load_data3 = data;
      tick();
      load_en1 = 1'b0; load_en3 = 1'b0;
      model[idx] = data;
   endtask

   // Expected response from the plain address rules.
   function automatic logic [32:0] expect_resp(input logic [31:0] addr);
      if (addr[1:0] != 2'b00 || addr >= 32'd4096) return {1'b1, 32'h0};
      return {1'b0, model[addr / 4]};
   endfunction

   // Drives one read on the LAT=3 responder and reports what was observed.
   task automatic read3(input logic [31:0] addr, input int hold,
                        output logic [31:0] data, output logic err, output int lat,
                        output bit rdy_in_wait, output bit busy_low, output bit unstable);
      int k;
      bus3.req_valid = 1'b1; bus3.req_addr = addr; bus3.resp_ready = 1'b0;
      #1;
      k = 0;
      while (!bus3.req_ready && k < 20) begin tick(); k++; end
      tick();
      bus3.req_valid = 1'b0; bus3.req_addr = $urandom;
      lat = 1; rdy_in_wait = 0; busy_low = 0;
      while (!bus3.resp_valid && lat < 20) begin
         if (bus3.req_ready) rdy_in_wait = 1;
         if (!busy3) busy_low = 1;
         tick(); lat++;
      end
      data = bus3.resp_data; err = bus3.resp_err;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!bus3.resp_valid || bus3.resp_data !== data || bus3.resp_err !== err ||
             bus3.req_ready || !busy3) unstable = 1;
      end
      bus3.resp_ready = 1'b1;
      tick();
      bus3.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      tests++;
      if ({bus3.resp_valid, busy3, bus3.resp_err, bus3.resp_data} !== 35'h0) begin
         fails++;
         $display("FAIL reset_state3: got v=%b b=%b e=%b d=%h required all zero",
                  bus3.resp_valid, busy3, bus3.resp_err, bus3.resp_data);
      end
      tests++;
      if ({bus1.resp_valid, busy1} !== 2'b00) begin
         fails++; $display("FAIL reset_state1: got v=%b b=%b required 0 0", bus1.resp_valid, busy1);
      end
      tests++;
      if (bus3.req_ready !== 1'b1) begin
         fails++; $display("FAIL reset_req_ready: got %b required 1", bus3.req_ready);
      end
      load_en3 = 1'b1; load_addr3 = 10'd0; load_data3 = 32'h0;
      #1;
      tests++;
      if (bus3.req_ready !== 1'b0) begin
         fails++; $display("FAIL reset_load_blocks_ready: got %b required 0", bus3.req_ready);
      end
      load_en3 = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lat1_stream();
      int idx;
      logic [32:0] e;
      bus1.resp_ready = 1'b1; bus1.req_valid = 1'b1; bus1.req_addr = 32'h0;
      tick();
      tests++;
      if (bus1.resp_valid !== 1'b1 || bus1.resp_data !== 32'h3C01_0005) begin
         fails++; $display("FAIL lat1_word0: got v=%b d=%h required 1 3c010005", bus1.resp_valid, bus1.resp_data);
      end
      bus1.req_addr = 32'h4;
      tick();
      tests++;
      if (bus1.resp_valid !== 1'b1 || bus1.resp_data !== 32'h2022_0001) begin
         fails++; $display("FAIL lat1_word1: got v=%b d=%h required 1 20220001", bus1.resp_valid, bus1.resp_data);
      end
      for (int i = 0; i < 20; i++) begin
         idx = $urandom_range(0, 63);
         bus1.req_addr = 32'(idx * 4);
         e = expect_resp(bus1.req_addr);
         tick();
         tests++;
         if (bus1.resp_valid !== 1'b1 || {bus1.resp_err, bus1.resp_data} !== e) begin
            fails++;
            $display("FAIL lat1_stream[%0d]: got v=%b e=%b d=%h required 1 %b %h",
                     i, bus1.resp_valid, bus1.resp_err, bus1.resp_data, e[32], e[31:0]);
         end
      end
      bus1.req_valid = 1'b0;
      tick();
      tests++;
      if (bus1.resp_valid !== 1'b0 || busy1 !== 1'b0) begin
         fails++; $display("FAIL lat1_drain: got v=%b b=%b required 0 0", bus1.resp_valid, busy1);
      end
      bus1.resp_ready = 1'b0;
   endtask

   task automatic test_latency();
      logic [31:0] d; logic er; int lat; bit rw, bl, us;
      read3(32'h8, 0, d, er, lat, rw, bl, us);
      tests++;
      if (lat != 3) begin fails++; $display("FAIL latency3: got %0d required 3", lat); end
      tests++;
      if (rw || bl) begin
         fails++; $display("FAIL wait_ready_busy: got ready_seen=%b busy_low=%b required 0 0", rw, bl);
      end
      tests++;
      if ({er, d} !== {1'b0, model[2]}) begin
         fails++; $display("FAIL latency3_data: got %b %h required 0 %h", er, d, model[2]);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic er; int lat; bit rw, bl, us;
      read3(32'h14, 5, d, er, lat, rw, bl, us);
      tests++;
      if (us) begin fails++; $display("FAIL hold_stable: got unstable=1 required 0"); end
      tests++;
      if (d !== model[5]) begin fails++; $display("FAIL hold_data: got %h required %h", d, model[5]); end
      tests++;
      if (bus3.resp_valid !== 1'b0 || busy3 !== 1'b0) begin
         fails++; $display("FAIL hold_release: got v=%b b=%b required 0 0", bus3.resp_valid, busy3);
      end
   endtask

   task automatic test_error();
      logic [31:0] d; logic er; int lat; bit rw, bl, us;
      logic [31:0] addrs [3];
      addrs[0] = 32'h6; addrs[1] = 32'h1000; addrs[2] = 32'hFFFF_FFFC;
      for (int i = 0; i < 3; i++) begin
         read3(addrs[i], 1, d, er, lat, rw, bl, us);
         tests++;
         if (er !== 1'b1 || d !== 32'h0 || lat != 3) begin
            fails++; $display("FAIL error[%h]: got e=%b d=%h lat=%0d required 1 0 3", addrs[i], er, d, lat);
         end
      end
   endtask

   task automatic test_load_during_wait();
      logic [31:0] d; logic er; int lat; bit rw, bl, us;
      logic [31:0] a, b;
      int k;
      a = $urandom; b = ~a;
      load_both(3, a);
      bus3.req_valid = 1'b1; bus3.req_addr = 32'hC;
      tick();
      bus3.req_valid = 1'b0;
      load_both(3, b);
      k = 0;
      while (!bus3.resp_valid && k < 10) begin tick(); k++; end
      tests++;
      if (bus3.resp_valid !== 1'b1 || bus3.resp_data !== a) begin
         fails++; $display("FAIL inflight_data: got v=%b d=%h required 1 %h", bus3.resp_valid, bus3.resp_data, a);
      end
      bus3.resp_ready = 1'b1; tick(); bus3.resp_ready = 1'b0;
      read3(32'hC, 0, d, er, lat, rw, bl, us);
      tests++;
      if (d !== b) begin fails++; $display("FAIL reread_data: got %h required %h", d, b); end
      load_en3 = 1'b1; load_addr3 = 10'd5; load_data3 = model[5];
      bus3.req_valid = 1'b1; bus3.req_addr = 32'h14;
      #1;
      tests++;
      if (bus3.req_ready !== 1'b0) begin fails++; $display("FAIL load_blocks_req: got %b required 0", bus3.req_ready); end
      tick();
      load_en3 = 1'b0; bus3.req_valid = 1'b0;
      tests++;
      if (busy3 !== 1'b0) begin fails++; $display("FAIL load_no_accept: got busy=%b required 0", busy3); end
   endtask

   task automatic test_random();
      logic [31:0] d, addr; logic er; int lat; bit rw, bl, us;
      logic [32:0] e;
      int kind;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) load_both($urandom_range(0, 63), $urandom);
         kind = $urandom_range(0, 5);
         if (kind == 0)      addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
         else if (kind == 1) addr = {$urandom_range(1, 1023), 2'b00} << 10;
         else                addr = 32'($urandom_range(0, 63) * 4);
         e = expect_resp(addr);
         read3(addr, $urandom_range(0, 3), d, er, lat, rw, bl, us);
         tests++;
         if ({er, d} !== e || lat != 3 || us) begin
            fails++;
            $display("FAIL random[%0d] addr=%h: got e=%b d=%h lat=%0d unstable=%b required %b %h 3 0",
                     i, addr, er, d, lat, us, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic er; int lat; bit rw, bl, us;
      bus3.req_valid = 1'b1; bus3.req_addr = 32'h10;
      tick();
      bus3.req_valid = 1'b0;
      rst = 1'b1;
      tick();
      tests++;
      if (bus3.resp_valid !== 1'b0 || busy3 !== 1'b0) begin
         fails++; $display("FAIL reset_mid: got v=%b b=%b required 0 0", bus3.resp_valid, busy3);
      end
      bus3.req_valid = 1'b1; bus3.req_addr = 32'h10;
      tick();
      rst = 1'b0;
      tick();
      tests++;
      if (busy3 !== 1'b1) begin fails++; $display("FAIL held_req_after_reset: got busy=%b required 1", busy3); end
      bus3.req_valid = 1'b0;
      repeat (3) tick();
      bus3.resp_ready = 1'b1; tick(); bus3.resp_ready = 1'b0;
      read3(32'h4, 0, d, er, lat, rw, bl, us);
      tests++;
      if (d !== model[1] || er !== 1'b0) begin
         fails++; $display("FAIL mem_kept: got e=%b d=%h required 0 %h", er, d, model[1]);
      end
   endtask

   initial begin
      bus1.req_valid = 1'b0; bus1.req_addr = 32'h0; bus1.resp_ready = 1'b0;
      bus3.req_valid = 1'b0; bus3.req_addr = 32'h0; bus3.resp_ready = 1'b0;
      load_en1 = 1'b0; load_addr1 = 10'd0; load_data1 = 32'h0;
      load_en3 = 1'b0; load_addr3 = 10'd0; load_data3 = 32'h0;
      test_reset();
      for (int i = 0; i < 64; i++) load_both(i, $urandom);
      load_both(0, 32'h3C01_0005);
      load_both(1, 32'h2022_0001);
      test_lat1_stream();
      test_latency();
      test_backpressure();
      test_error();
      test_load_during_wait();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
